// File: rtl/sobel_scan_ctrl.sv
// Raster-scan front end of the Sobel pipeline: counts column/row for an
// incoming pixel stream and forwards each pixel through one tagged register.
module sobel_scan_ctrl #(
   parameter int IMG_W_P  = 640,
   parameter int IMG_H_P  = 480,
   parameter int DATA_W_P = 8,
   parameter int XW_P     = 10,
   parameter int YW_P     = 9
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [DATA_W_P-1:0] data_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic [DATA_W_P-1:0] data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [XW_P-1:0]     x_o,
   output logic [YW_P-1:0]     y_o,
   output logic                sof_o,
   output logic                eol_o,
   output logic                eof_o,
   output logic                win_valid_o,
   output logic                busy_o,
   output logic                done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [XW_P-1:0] X_LAST = XW_P'(IMG_W_P - 1);
   localparam logic [YW_P-1:0] Y_LAST = YW_P'(IMG_H_P - 1);
   localparam logic [XW_P-1:0] X_TWO  = XW_P'(2);
   localparam logic [YW_P-1:0] Y_TWO  = YW_P'(2);

   state_t          state;
   state_t          state_nx;
   logic [XW_P-1:0] x_q;
   logic [YW_P-1:0] y_q;
   logic            accept;
   logic            xfer;
   logic            x_last;
   logic            y_last;

   assign ready_o = (state == RUN) & (~valid_o | ready_i);
   assign accept  = valid_i & ready_o;
   assign xfer    = valid_o & ready_i;
   assign x_last  = (x_q == X_LAST);
   assign y_last  = (y_q == Y_LAST);
   assign busy_o  = (state != IDLE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start_i) state_nx = RUN;
         end
         RUN: begin
            if (accept && x_last && y_last) state_nx = DRAIN;
         end
         DRAIN: begin
            if (xfer && eof_o) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (abort_i) state_nx = IDLE;
   end

   // Counters wrap at frame end too, so they never leave the image
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         x_q <= '0;
         y_q <= '0;
      end else if (abort_i || (state == IDLE && start_i)) begin
         x_q <= '0;
         y_q <= '0;
      end else if (accept) begin
         if (x_last) begin
            x_q <= '0;
            y_q <= y_last ? '0 : y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         x_o         <= '0;
         y_o         <= '0;
         sof_o       <= 1'b0;
         eol_o       <= 1'b0;
         eof_o       <= 1'b0;
         win_valid_o <= 1'b0;
         done_o      <= 1'b0;
      end else if (abort_i) begin
         valid_o <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         done_o <= (state == DRAIN) & xfer & eof_o;
         if (accept) begin
            data_o      <= data_i;
            valid_o     <= 1'b1;
            x_o         <= x_q;
            y_o         <= y_q;
            sof_o       <= (x_q == '0) && (y_q == '0);
            eol_o       <= x_last;
            eof_o       <= x_last && y_last;
            win_valid_o <= (x_q >= X_TWO) && (y_q >= Y_TWO);
         end else if (xfer) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule
